sweep_measure_ctrl: RTL

Measurement sequencer between the frequency-tracking algorithm and the resonant power stage. It accepts one frequency point at a time over a valid/ready handshake and drives the power stage at that frequency. It waits a settle time, captures the peak of the envelope-max stream over a measurement window, then gates the stage off for a cool-down. It returns the (frequency, peak) result over a second valid/ready handshake, so sweep algorithms no longer embed their own delay and disable counters.

---
 rtl/sweep_measure_ctrl.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/sweep_measure_ctrl.sv
// sweep_measure_ctrl: sequences one sweep point through settle, envelope-peak measure, power-off cool-down, report.
// Latency: result valid on the (SETTLE_CYCLES+WINDOW_CYCLES+OFF_CYCLES+1)th edge counting the accepting edge.
// Backpressure: one point in flight; o_req_ready only in IDLE, REPORT holds all o_res_* stable until i_res_ready.
//
// Ports:
//   i_clk, i_nrst                        clock, synchronous active-low reset
//   i_req_valid/o_req_ready/i_req_freq   request handshake carrying the frequency to measure
//   i_envelope_max                       signed envelope peak sample, one per cycle
//   o_freq, o_enable                     power stage frequency and enable
//   o_res_valid/i_res_ready              result handshake
//   o_res_freq, o_res_peak, o_res_abort  result payload
//   o_busy                               high whenever a point is in flight
//
// Optional feature macro: OVERLIMIT_ABORT_EN -- a sample above LIMIT while settling or
// measuring cuts the point short, goes straight to cool-down and flags o_res_abort.

module sweep_measure_ctrl #(
  parameter int                 FREQ_W        = 32,
  parameter int                 AMP_W         = 12,
  parameter logic [FREQ_W-1:0]  DEFAULT_FREQ  = FREQ_W'(1000),
  parameter int unsigned        SETTLE_CYCLES = 1200000,
  parameter int unsigned        WINDOW_CYCLES = 1024,
  parameter int unsigned        OFF_CYCLES    = 400000,
  parameter int                 LIMIT         = 2000
) (
  input  logic                     i_clk,
  input  logic                     i_nrst,
  input  logic                     i_req_valid,
  input  logic [FREQ_W-1:0]        i_req_freq,
  output logic                     o_req_ready,
  input  logic signed [AMP_W-1:0]  i_envelope_max,
  output logic [FREQ_W-1:0]        o_freq,
  output logic                     o_enable,
  output logic                     o_res_valid,
  input  logic                     i_res_ready,
  output logic [FREQ_W-1:0]        o_res_freq,
  output logic signed [AMP_W-1:0]  o_res_peak,
  output logic                     o_res_abort,
  output logic                     o_busy
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_MEASURE = 3'd2,
    ST_OFF     = 3'd3,
    ST_REPORT  = 3'd4
  } state_t;

  // Terminal counts: the counter starts at 0 on state entry, so a phase of N
  // cycles ends on the edge where the counter reads N-1.
  localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYCLES - 1);
  localparam logic [31:0] WINDOW_LAST = 32'(WINDOW_CYCLES - 1);
  localparam logic [31:0] OFF_LAST    = 32'(OFF_CYCLES - 1);

  // Most negative sample: any real sample wins the first compare.
  localparam logic signed [AMP_W-1:0] PEAK_MIN = {1'b1, {(AMP_W-1){1'b0}}};

  state_t                    state;
  logic [31:0]               cnt;
  logic signed [AMP_W-1:0]   peak;
  logic signed [AMP_W-1:0]   nxt_peak;

  // Running maximum including the sample on the current edge.
  always_comb begin
    nxt_peak = peak;
    if (i_envelope_max > peak) begin
      nxt_peak = i_envelope_max;
    end
  end

`ifdef OVERLIMIT_ABORT_EN
  logic over_limit;
  assign over_limit = (i_envelope_max > LIMIT);
`else
  // No threshold logic in this build; the abort flag is tied off.
  logic unused_limit;
  assign unused_limit = (LIMIT != 0);
  assign o_res_abort  = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      peak        <= '0;
      o_freq      <= DEFAULT_FREQ;
      o_enable    <= 1'b0;
      o_req_ready <= 1'b0;
      o_res_valid <= 1'b0;
      o_res_freq  <= '0;
      o_res_peak  <= '0;
      o_busy      <= 1'b0;
`ifdef OVERLIMIT_ABORT_EN
      o_res_abort <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          // Stage stays parked at the last frequency while waiting.
          o_enable <= 1'b1;
          if (i_req_valid && o_req_ready) begin
            o_freq      <= i_req_freq;
            o_res_freq  <= i_req_freq;
            o_req_ready <= 1'b0;
            o_busy      <= 1'b1;
            cnt         <= '0;
            state       <= ST_SETTLE;
`ifdef OVERLIMIT_ABORT_EN
            o_res_abort <= 1'b0;
`endif
          end else begin
            o_req_ready <= 1'b1;
          end
        end

        ST_SETTLE: begin
`ifdef OVERLIMIT_ABORT_EN
          if (over_limit) begin
            o_res_peak  <= i_envelope_max;
            o_res_abort <= 1'b1;
            o_enable    <= 1'b0;
            cnt         <= '0;
            state       <= ST_OFF;
          end else
`endif
          if (cnt == SETTLE_LAST) begin
            // The sample on this edge belongs to settling and is not taken.
            peak  <= PEAK_MIN;
            cnt   <= '0;
            state <= ST_MEASURE;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        ST_MEASURE: begin
`ifdef OVERLIMIT_ABORT_EN
          if (over_limit) begin
            o_res_peak  <= i_envelope_max;
            o_res_abort <= 1'b1;
            o_enable    <= 1'b0;
            cnt         <= '0;
            state       <= ST_OFF;
          end else
`endif
          if (cnt == WINDOW_LAST) begin
            // Last sample of the window folds straight into the result.
            o_res_peak <= nxt_peak;
            o_enable   <= 1'b0;
            cnt        <= '0;
            state      <= ST_OFF;
          end else begin
            peak <= nxt_peak;
            cnt  <= cnt + 32'd1;
          end
        end

        ST_OFF: begin
          if (cnt == OFF_LAST) begin
            o_res_valid <= 1'b1;
            cnt         <= '0;
            state       <= ST_REPORT;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        ST_REPORT: begin
          if (i_res_ready) begin
            // Ready rises on IDLE entry so a waiting request is taken on the
            // first IDLE edge.
            o_res_valid <= 1'b0;
            o_busy      <= 1'b0;
            o_req_ready <= 1'b1;
            o_enable    <= 1'b1;
            cnt         <= '0;
            state       <= ST_IDLE;
          end
        end

        default: begin
          state       <= ST_IDLE;
          cnt         <= '0;
          o_enable    <= 1'b0;
          o_req_ready <= 1'b0;
          o_res_valid <= 1'b0;
          o_busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
